// File: rtl/prf_freelist.sv
// prf_freelist
//   Checkpointed physical-register free list for the superscalar rename stage.
//   Holds a speculative free bitmap (rename allocations + retirement frees)
//   and an architectural free bitmap (commits + frees).  Squash copies the
//   architectural view, including that cycle's commit/free, into the
//   speculative one.  Up to WAYS free tags are offered to rename each cycle,
//   lowest index first.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high
//   avail_tag    WAYS*TW  slot k = k-th lowest free tag in the spec bitmap
//   avail_valid  WAYS     slot k holds a real free tag (thermometer)
//   alloc_en     WAYS     rename consumes avail_tag slot k this cycle
//   commit_en    WAYS     retirement lane k commits a new mapping
//   commit_tag   WAYS*TW  tag becoming architectural
//   free_en      WAYS     retirement lane k releases the previous mapping
//   free_tag     WAYS*TW  tag returned to the free list
//   squash       1        rollback of spec bitmap to the arch bitmap
//   free_count   registered popcount of the spec bitmap
//   num_avail    min(free_count, WAYS)
//   err          sticky protocol-violation flag
module prf_freelist #(
  parameter  int PRF       = 64,
  parameter  int WAYS      = 3,
  parameter  int ARCH_REGS = 32,
  localparam int TW        = $clog2(PRF),
  localparam int CW        = $clog2(PRF + 1),
  localparam int NW        = $clog2(WAYS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [WAYS*TW-1:0] avail_tag,
  output logic [WAYS-1:0]    avail_valid,
  input  logic [WAYS-1:0]    alloc_en,
  input  logic [WAYS-1:0]    commit_en,
  input  logic [WAYS*TW-1:0] commit_tag,
  input  logic [WAYS-1:0]    free_en,
  input  logic [WAYS*TW-1:0] free_tag,
  input  logic               squash,
  output logic [CW-1:0]      free_count,
  output logic [NW-1:0]      num_avail,
  output logic               err
);

  function automatic logic [PRF-1:0] init_free_map();
    logic [PRF-1:0] m;
    m = '0;
    for (int unsigned i = ARCH_REGS; i < PRF; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [PRF-1:0] INIT_FREE  = init_free_map();
  localparam logic [CW-1:0]  INIT_COUNT = CW'(PRF - ARCH_REGS);

  logic [PRF-1:0] spec_free, arch_free;
  logic [PRF-1:0] spec_next, arch_next;
  logic [PRF-1:0] alloc_mask, commit_mask, free_mask;
  logic [CW-1:0]  count_next;
  logic           viol;
  logic [TW-1:0]  slot_tag [WAYS];
  int unsigned    found;

  // Slot selection: walk the spec bitmap upward; the n-th set bit seen
  // lands in slot n.  Validity comes from the registered count, which
  // always equals the bitmap popcount, so the two agree.
  always_comb begin
    found = 0;
    for (int unsigned k = 0; k < WAYS; k++) slot_tag[k] = '0;
    for (int unsigned i = 0; i < PRF; i++) begin
      if (spec_free[i]) begin
        for (int unsigned k = 0; k < WAYS; k++)
          if (found == k) slot_tag[k] = TW'(i);
        found = found + 1;
      end
    end
  end

  always_comb begin
    avail_tag   = '0;
    avail_valid = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      avail_tag[k*TW +: TW] = slot_tag[k];
      avail_valid[k]        = (free_count > CW'(k));
    end
    num_avail = (free_count >= CW'(WAYS)) ? NW'(WAYS) : NW'(free_count);
  end

  // Next-state bitmaps.  free_mask is built lane by lane so a later lane
  // sees earlier lanes' bits, which is how duplicate frees are caught.
  always_comb begin
    alloc_mask  = '0;
    commit_mask = '0;
    free_mask   = '0;
    viol        = 1'b0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (alloc_en[k]) begin
        if (avail_valid[k]) alloc_mask[slot_tag[k]] = 1'b1;
        else                viol = 1'b1;
      end
      if (commit_en[k]) commit_mask[commit_tag[k*TW +: TW]] = 1'b1;
      if (free_en[k]) begin
        if (arch_free[free_tag[k*TW +: TW]] || free_mask[free_tag[k*TW +: TW]])
          viol = 1'b1;
        free_mask[free_tag[k*TW +: TW]] = 1'b1;
      end
    end
    arch_next = (arch_free & ~commit_mask) | free_mask;
    spec_next = squash ? arch_next : ((spec_free & ~alloc_mask) | free_mask);
    count_next = '0;
    for (int unsigned i = 0; i < PRF; i++)
      count_next = count_next + CW'(spec_next[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free  <= INIT_FREE;
      arch_free  <= INIT_FREE;
      free_count <= INIT_COUNT;
      err        <= 1'b0;
    end else begin
      spec_free  <= spec_next;
      arch_free  <= arch_next;
      free_count <= count_next;
      err        <= err | viol;
    end
  end

endmodule

// File: doc/prf_freelist.md
Name: prf_freelist

Overview:
- Checkpointed physical-register free list for the superscalar rename stage of the out-of-order RV32 core.
- Keeps two free bitmaps:
  - a speculative one, updated by rename allocations and retirement frees;
  - an architectural one, updated only at commit.
- Each cycle it offers up to WAYS free physical tags to rename.
- On squash it restores the speculative bitmap from the architectural one.
- Successor to the combinational multi-grant selector: adds state, a count, per-cycle free/commit, and rollback.

Parameters:
- PRF, 64, number of physical registers; tag width TW = $clog2(PRF).
- WAYS, 3, allocation, commit and free lanes per cycle.
- ARCH_REGS, 32, physical tags 0..ARCH_REGS-1 hold the initial architectural map and are not free at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- avail_tag  out  WAYS*TW  slot k = k-th lowest-index free tag in spec bitmap (combinational from registered state)
- avail_valid  out  WAYS  slot k holds a real free tag
- alloc_en  in  WAYS  rename consumes avail_tag[k] this cycle
- commit_en  in  WAYS  retirement lane k commits a new mapping
- commit_tag  in  WAYS*TW  physical tag becoming architectural
- free_en  in  WAYS  retirement lane k releases the previous mapping
- free_tag  in  WAYS*TW  physical tag returned to the free list
- squash  in  1  mispredict/exception rollback
- free_count  out  $clog2(PRF+1)  registered popcount of spec bitmap
- num_avail  out  $clog2(WAYS+1)  min(free_count, WAYS)
- err  out  1  registered sticky protocol-violation flag

Behaviour:
- Reset (synchronous, overrides everything):
  - spec_free = arch_free = 1 for tags ARCH_REGS..PRF-1, 0 otherwise.
  - free_count = PRF-ARCH_REGS.
  - err = 0.
  - Outputs after reset: avail_tag = ARCH_REGS, ARCH_REGS+1, ..., avail_valid all 1 (if enough free).
- Slot selection:
  - Slots are filled in strictly ascending tag order.
  - avail_valid is a prefix (thermometer): slot k valid iff free_count > k.
- Allocation:
  - alloc_en[k] with avail_valid[k]=1 clears spec_free[avail_tag[k]] at the next edge.
  - alloc_en may be any subset of the valid slots.
  - alloc_en[k] with avail_valid[k]=0 is ignored and sets err.
- Free:
  - free_en[k] sets spec_free[free_tag[k]] and arch_free[free_tag[k]] at the next edge.
  - No bypass: a freed tag becomes allocatable the cycle after it is freed.
  - Freeing a tag already set in arch_free sets err; the bit stays 1.
- Commit:
  - commit_en[k] clears arch_free[commit_tag[k]].
  - Commit does not change spec_free.
- Same-cycle ordering within one edge: arch update = arch & ~commit | free.
- Spec update without squash: spec & ~alloc | free.
- Squash:
  - spec_free <= the arch value after applying the same cycle's commit/free.
  - Same-cycle alloc_en is discarded.
  - Squash, commit and free may all assert in one cycle; the results are as above.
- free_count:
  - Recomputed from the next spec value and registered, so it matches the bitmap every cycle.
  - Never exceeds PRF-ARCH_REGS plus frees of initially mapped tags, and is bounded by PRF.
- Tag 0 is not special; the zero-register handling is rename's responsibility.
- Latency: alloc/free/commit/squash are visible on all outputs exactly one cycle after the edge that samples them.
- Empty: free_count=0 gives avail_valid=0 and num_avail=0; rename must stall. No state change without frees.
- Multiple lanes freeing the same tag in one cycle sets err; the bit is set once.

Test Plan:
- Reset (PRF=64, WAYS=3, ARCH_REGS=32) -> avail_tag 32,33,34, avail_valid 111, free_count 32, num_avail 3, err 0.
- alloc_en=111 for 10 cycles -> tags 32..61 consumed in order. Then avail_tag 62,63, avail_valid 011, free_count 2, num_avail 2. One more cycle with alloc_en=011 -> avail_valid 000, free_count 0.
- From empty, free_en[1]=1 with free_tag=5 at cycle t -> at t+1 avail_tag[0]=5, avail_valid 001, free_count 1. Nothing is available at t itself.
- Allocate 32,33,34 and commit 32 only, then squash -> avail_tag 33,34,35, free_count 31; arch_free[32]=0 is preserved.
- Same cycle: squash=1, commit tag 40, free tag 7, alloc_en=111 -> alloc discarded; next cycle spec==arch with bit 40=0 and bit 7=1; slot0=7.
- Mid-operation reset after 5 allocation cycles with squash asserted -> next cycle identical to the first reset scenario. alloc_en=001 while avail_valid=000 -> err=1 and held until reset.
